instr_loader: RTL and testbench

Boot-time writer for the CPU's 64-word instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one-cycle write strobes into a writable instruction memory port. While loading, it holds the CPU in reset. When the programmed word count has been written, it releases the CPU.

---
 rtl/instr_loader.sv | 166 ++++++++++++++++
 tb/tb_instr_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: assembles little-endian words from a byte stream and writes them.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   target;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic [23:0]       word;
    logic              len_bad;
    logic              last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        xor_acc;
`endif

    assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > 9'(DEPTH));
    assign last_word = ((words_loaded + 1'b1) == target);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN, S_DATA: in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK:         in_ready = 1'b1;
`endif
            default:       in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            target       <= '0;
            addr         <= '0;
            byte_idx     <= 2'd0;
            word         <= 24'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_acc      <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LEN;
                end
                S_LEN: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_acc <= 8'd0;
`endif
                    if (in_valid) begin
                        target       <= in_data[ADDR_W:0];
                        words_loaded <= '0;
                        addr         <= '0;
                        byte_idx     <= 2'd0;
                        if (len_bad) begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ in_data;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word[7:0]   <= in_data;
                            2'd1: word[15:8]  <= in_data;
                            2'd2: word[23:16] <= in_data;
                            default: begin
                                // Final byte bypasses the holding register straight into the write data.
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= {in_data, word};
                                state     <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    addr         <= addr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (in_valid) begin
                        if (in_data == xor_acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (start) begin
                        state    <= S_LEN;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (start) begin
                        state <= S_LEN;
                        err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued by the stimulus, a monitor pops them on mem_we.
// Also follows the INSTR_LOADER_CHECKSUM_EN build option when defined.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    instr_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam int LOAD2_LAT = 12;
`else
    localparam int LOAD2_LAT = 11;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          we_count = 0;
    int          start_cyc = 0;
    int          end_cyc = 0;
    logic [37:0] exp_q [$];
    logic [31:0] words [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            logic [37:0] e;
            we_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", 64'(mem_addr), 64'(e[37:32]));
                checkOutput("write_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic applyStimulus(input logic [7:0] len, input int nw, input int gap, input bit corrupt);
        logic [7:0] x = 8'd0;
        pulse_start();
        send_byte(len, gap);
        for (int w = 0; w < nw; w++) begin
            exp_q.push_back({6'(w), words[w]});
            for (int k = 0; k < 4; k++) begin
                x = x ^ words[w][8*k +: 8];
                send_byte(words[w][8*k +: 8], gap);
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (nw > 0) send_byte(x ^ {7'd0, corrupt}, gap);
`else
        if (corrupt) x = 8'd0;
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (!(done || err) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) checkOutput("end_timeout", 64'(done || err), 64'd1);
        end_cyc = cyc;
    endtask

    initial begin
        bit saw_ready;

        #1 rst_n = 1'b0;
        #20;
        checkOutput("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_done_err", 64'({done, err, mem_we}), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Two-word load, contiguous bytes
        words[0] = 32'h0000_0113;
        words[1] = 32'h0010_0093;
        we_count = 0;
        applyStimulus(8'h02, 2, 0, 1'b0);
        wait_end();
        checkOutput("load2_latency", 64'(end_cyc - start_cyc), 64'(LOAD2_LAT));
        checkOutput("load2_done", 64'(done), 64'd1);
        checkOutput("load2_err", 64'(err), 64'd0);
        checkOutput("load2_cpu_hold", 64'(cpu_hold), 64'd0);
        checkOutput("load2_words", 64'(words_loaded), 64'd2);
        checkOutput("load2_we_count", 64'(we_count), 64'd2);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_cpu_hold", 64'(cpu_hold), 64'd1);
        checkOutput("async_flags", 64'({in_ready, mem_we, done, err}), 64'd0);
        checkOutput("async_addr", 64'(mem_addr), 64'd0);
        checkOutput("async_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("async_words", 64'(words_loaded), 64'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) saw_ready = 1'b1;
        end
        checkOutput("idle_in_ready", 64'(saw_ready), 64'd0);
        checkOutput("idle_cpu_hold", 64'(cpu_hold), 64'd1);
        in_valid = 1'b0;

        // Same stream with a one-cycle gap between bytes
        we_count = 0;
        applyStimulus(8'h02, 2, 1, 1'b0);
        wait_end();
        checkOutput("gap_done", 64'(done), 64'd1);
        checkOutput("gap_words", 64'(words_loaded), 64'd2);
        checkOutput("gap_we_count", 64'(we_count), 64'd2);

        // Illegal lengths, then recovery
        we_count = 0;
        applyStimulus(8'h00, 0, 0, 1'b0);
        wait_end();
        checkOutput("len0_err", 64'({err, cpu_hold, done}), 64'b110);
        applyStimulus(8'h41, 0, 0, 1'b0);
        wait_end();
        checkOutput("len41_err", 64'({err, cpu_hold, done}), 64'b110);
        checkOutput("illegal_we_count", 64'(we_count), 64'd0);
        words[0] = 32'hCAFE_BABE;
        applyStimulus(8'h01, 1, 0, 1'b0);
        wait_end();
        checkOutput("recover_flags", 64'({err, done, cpu_hold}), 64'b010);
        checkOutput("recover_words", 64'(words_loaded), 64'd1);

        // Full-depth load
        for (int i = 0; i < 64; i++) words[i] = {i[7:0], 8'hA5 ^ i[7:0], 8'h3C, 8'h10 + i[7:0]};
        we_count = 0;
        applyStimulus(8'h40, 64, 0, 1'b0);
        wait_end();
        checkOutput("full_done", 64'(done), 64'd1);
        checkOutput("full_words", 64'(words_loaded), 64'd64);
        checkOutput("full_we_count", 64'(we_count), 64'd64);

`ifdef INSTR_LOADER_CHECKSUM_EN
        words[0] = 32'hDDCC_BBAA;
        applyStimulus(8'h01, 1, 0, 1'b0);
        wait_end();
        checkOutput("csum_ok_flags", 64'({done, err, cpu_hold}), 64'b100);
        we_count = 0;
        applyStimulus(8'h01, 1, 0, 1'b1);
        wait_end();
        checkOutput("csum_bad_flags", 64'({done, err, cpu_hold}), 64'b011);
        checkOutput("csum_bad_we_count", 64'(we_count), 64'd1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
